// File: rtl/maxnet_engine.sv
// maxnet_engine: winner-take-all (MaxNet) engine over N signed fixed-point channels.
// Performs one full mutual-inhibition update per clock until at most one activation survives.
module maxnet_engine #(
  parameter int N        = 4,
  parameter int W        = 32,
  parameter int FRAC     = 16,
  parameter int EPS      = 16384,
  parameter int MAX_ITER = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N*W-1:0]                x_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [W-1:0]                  result,
  output logic [$clog2(N)-1:0]          winner_idx,
  output logic [$clog2(MAX_ITER+1)-1:0] iterations,
  output logic                          tie,
  output logic                          timeout
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(MAX_ITER + 1);
  localparam int NW = $clog2(N + 1);
  localparam int SW = W + $clog2(N);
  localparam int PW = W + SW;

  localparam logic signed [PW-1:0] EPS_EXT = PW'(EPS);
  localparam logic signed [PW-1:0] P_MAX   = {{(PW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [PW-1:0] P_MIN   = {{(PW-W+1){1'b1}}, {(W-1){1'b0}}};
  localparam logic signed [W-1:0]  A_MAX   = {1'b0, {(W-1){1'b1}}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_nx;

  logic signed [W-1:0]  x_reg [N];
  logic signed [W-1:0]  a_reg [N];
  logic [N-1:0]         prev_mask;
  logic [CW-1:0]        iter_cnt;

  logic [N-1:0]         nz_mask;
  logic [NW-1:0]        nz_cnt;
  logic signed [SW-1:0] sum;

  logic signed [SW-1:0] d_arr    [N];
  logic signed [PW-1:0] prod_arr [N];
  logic signed [PW-1:0] shp_arr  [N];
  logic signed [W-1:0]  p_arr    [N];
  logic signed [W:0]    diff_arr [N];
  logic signed [W-1:0]  a_nx     [N];

  logic [IW-1:0]        nz_idx, prev_idx, max_idx, win_sel;
  logic signed [W-1:0]  max_val;
  logic                 accept, step, finish, tie_nx, timeout_nx;

  // Population summary of the current activations
  always_comb begin
    sum     = '0;
    nz_mask = '0;
    nz_cnt  = '0;
    for (int i = 0; i < N; i++) begin
      sum        = sum + SW'(a_reg[i]);
      nz_mask[i] = (a_reg[i] != '0);
      if (a_reg[i] != '0) nz_cnt = nz_cnt + NW'(1);
    end
  end

  // Inhibition update: a_i - sat((EPS * (S - a_i)) >>> FRAC), clamped to [0, max]
  always_comb begin
    for (int i = 0; i < N; i++) begin
      d_arr[i]    = sum - SW'(a_reg[i]);
      prod_arr[i] = EPS_EXT * PW'(d_arr[i]);
      shp_arr[i]  = prod_arr[i] >>> FRAC;
      if (shp_arr[i] > P_MAX)
        p_arr[i] = P_MAX[W-1:0];
      else if (shp_arr[i] < P_MIN)
        p_arr[i] = P_MIN[W-1:0];
      else
        p_arr[i] = shp_arr[i][W-1:0];
      diff_arr[i] = (W+1)'(a_reg[i]) - (W+1)'(p_arr[i]);
      if (diff_arr[i][W] || (diff_arr[i] == '0))
        a_nx[i] = '0;
      else if (diff_arr[i][W-1])
        a_nx[i] = A_MAX;
      else
        a_nx[i] = diff_arr[i][W-1:0];
    end
  end

  // Candidate winners: surviving channel, lowest previously live channel, strongest channel
  always_comb begin
    nz_idx   = '0;
    prev_idx = '0;
    max_idx  = '0;
    max_val  = a_reg[0];
    for (int i = N - 1; i >= 0; i--) begin
      if (nz_mask[i])   nz_idx   = IW'(i);
      if (prev_mask[i]) prev_idx = IW'(i);
    end
    for (int i = 1; i < N; i++) begin
      if (a_reg[i] > max_val) begin
        max_val = a_reg[i];
        max_idx = IW'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next state and datapath strobes; termination rules are checked in priority order
  always_comb begin
    state_nx   = state;
    accept     = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    win_sel    = '0;
    tie_nx     = 1'b0;
    timeout_nx = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          accept   = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (nz_cnt == NW'(1)) begin
          finish  = 1'b1;
          win_sel = nz_idx;
        end else if (nz_cnt == '0) begin
          finish  = 1'b1;
          win_sel = prev_idx;
          tie_nx  = 1'b1;
        end else if (iter_cnt == CW'(MAX_ITER)) begin
          finish     = 1'b1;
          win_sel    = max_idx;
          timeout_nx = 1'b1;
        end else begin
          step = 1'b1;
        end
        if (finish) state_nx = DONE;
      end
      DONE: begin
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        x_reg[i] <= '0;
        a_reg[i] <= '0;
      end
      prev_mask  <= '0;
      iter_cnt   <= '0;
      result     <= '0;
      winner_idx <= '0;
      iterations <= '0;
      tie        <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      if (accept) begin
        for (int i = 0; i < N; i++) begin
          x_reg[i] <= x_in[i*W +: W];
          a_reg[i] <= x_in[i*W+W-1] ? '0 : x_in[i*W +: W];
        end
        prev_mask <= '1;
        iter_cnt  <= '0;
      end
      if (step) begin
        for (int i = 0; i < N; i++) a_reg[i] <= a_nx[i];
        prev_mask <= nz_mask;
        iter_cnt  <= iter_cnt + CW'(1);
      end
      if (finish) begin
        result     <= x_reg[win_sel];
        winner_idx <= win_sel;
        iterations <= iter_cnt;
        tie        <= tie_nx;
        timeout    <= timeout_nx;
      end
    end
  end

endmodule

// File: tb/tb_maxnet_engine.sv
// tb_maxnet_engine: directed checks of maxnet_engine at EPS=0.25 (dut_a) and EPS just under 1.0 (dut_b).
module tb_maxnet_engine;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int IW = 2;
  localparam int CW = 7;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic out_ready = 1'b0;
  logic in_valid_a = 1'b0, in_valid_b = 1'b0;
  logic [N*W-1:0] x_in_a = '0, x_in_b = '0;

  logic in_ready_a, out_valid_a, tie_a, timeout_a;
  logic in_ready_b, out_valid_b, tie_b, timeout_b;
  logic [W-1:0]  result_a, result_b;
  logic [IW-1:0] winner_idx_a, winner_idx_b;
  logic [CW-1:0] iterations_a, iterations_b;

  bit selB = 1'b0;
  int errors = 0;
  int checks = 0;

  wire          ov    = selB ? out_valid_b  : out_valid_a;
  wire          ir    = selB ? in_ready_b   : in_ready_a;
  wire [W-1:0]  res   = selB ? result_b     : result_a;
  wire [IW-1:0] win   = selB ? winner_idx_b : winner_idx_a;
  wire [CW-1:0] its   = selB ? iterations_b : iterations_a;
  wire          tie_s = selB ? tie_b        : tie_a;
  wire          to_s  = selB ? timeout_b    : timeout_a;

  maxnet_engine #(.N(N), .W(W), .FRAC(16), .EPS(16384), .MAX_ITER(64)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a), .x_in(x_in_a),
    .out_valid(out_valid_a), .out_ready(out_ready), .result(result_a),
    .winner_idx(winner_idx_a), .iterations(iterations_a), .tie(tie_a), .timeout(timeout_a)
  );

  maxnet_engine #(.N(N), .W(W), .FRAC(16), .EPS(65535), .MAX_ITER(64)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b), .x_in(x_in_b),
    .out_valid(out_valid_b), .out_ready(out_ready), .result(result_b),
    .winner_idx(winner_idx_b), .iterations(iterations_b), .tie(tie_b), .timeout(timeout_b)
  );

  always #5 clk = ~clk;

  function automatic logic [N*W-1:0] pack4(input int x0, input int x1, input int x2, input int x3);
    return {x3, x2, x1, x0};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Handshake one vector into the selected engine and count edges until out_valid
  task automatic applyStimulus(input bit useB, input logic [N*W-1:0] vec, output int lat);
    selB = useB;
    @(negedge clk);
    checkOutput("in_ready_idle", ir, 1);
    if (useB) begin x_in_b = vec; in_valid_b = 1'b1; end
    else      begin x_in_a = vec; in_valid_a = 1'b1; end
    @(posedge clk);
    #1;
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
    lat = 0;
    while (!ov && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic expectRun(input string tag, input int lat, input int eLat, input int eWin,
                           input int eRes, input int eIt, input int eTie, input int eTo);
    checkOutput({tag, "_latency"}, lat, eLat);
    checkOutput({tag, "_out_valid"}, ov, 1);
    checkOutput({tag, "_winner"}, win, eWin);
    checkOutput({tag, "_result"}, res, eRes);
    checkOutput({tag, "_iterations"}, its, eIt);
    checkOutput({tag, "_tie"}, tie_s, eTie);
    checkOutput({tag, "_timeout"}, to_s, eTo);
  endtask

  task automatic finishRun(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput({tag, "_ov_drop"}, ov, 0);
    checkOutput({tag, "_ready_back"}, ir, 1);
  endtask

  initial begin
    int lat;
    $display("[TB] maxnet_engine directed test");

    #12;
    selB = 1'b0;
    checkOutput("rst_in_ready", in_ready_a, 1);
    checkOutput("rst_out_valid", out_valid_a, 0);
    checkOutput("rst_result", result_a, 0);
    checkOutput("rst_iterations", iterations_a, 0);
    checkOutput("rst_flags", {tie_a, timeout_a, winner_idx_a}, 0);
    @(negedge clk);
    rst = 1'b1;

    applyStimulus(0, pack4(65536, 32768, 16384, 49152), lat);
    expectRun("converge", lat, 5, 0, 65536, 4, 0, 0);
    finishRun("converge");

    applyStimulus(0, pack4(0, 0, -100, 70000), lat);
    expectRun("immediate", lat, 1, 3, 70000, 0, 0, 0);
    finishRun("immediate");

    applyStimulus(0, pack4(32768, 32768, 0, 0), lat);
    expectRun("timeout_a", lat, 65, 0, 32768, 64, 0, 1);
    finishRun("timeout_a");

    applyStimulus(0, pack4(-5, 0, 0, 0), lat);
    expectRun("all_zero", lat, 1, 0, -5, 0, 1, 0);
    finishRun("all_zero");

    applyStimulus(1, pack4(0, 0, 32768, 32768), lat);
    expectRun("eps1_stuck", lat, 65, 2, 32768, 64, 0, 1);
    finishRun("eps1_stuck");

    applyStimulus(1, pack4(0, 0, 98304, 65536), lat);
    expectRun("eps1_win", lat, 2, 2, 98304, 1, 0, 0);
    finishRun("eps1_win");

    applyStimulus(1, pack4(0, 0, 65536, 65536), lat);
    expectRun("eps1_ones", lat, 65, 2, 65536, 64, 0, 1);
    finishRun("eps1_ones");

    applyStimulus(1, pack4(1, 1, 1, 0), lat);
    expectRun("eps1_tie", lat, 2, 0, 1, 1, 1, 0);
    finishRun("eps1_tie");

    // Hold the result with out_ready low while stray in_valid pulses arrive
    applyStimulus(0, pack4(10, 0, 0, 0), lat);
    expectRun("hold", lat, 1, 0, 10, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid_a = (i % 2 == 0);
      x_in_a = pack4(999, 888, 777, 666);
      @(posedge clk);
      #1;
      checkOutput("hold_ov", out_valid_a, 1);
      checkOutput("hold_in_ready", in_ready_a, 0);
      checkOutput("hold_result", result_a, 10);
      checkOutput("hold_winner", winner_idx_a, 0);
    end
    @(negedge clk);
    in_valid_a = 1'b0;
    finishRun("hold");

    applyStimulus(0, pack4(65536, 32768, 16384, 49152), lat);
    expectRun("back2back", lat, 5, 0, 65536, 4, 0, 0);
    finishRun("back2back");

    // Asynchronous reset in the middle of a long run
    selB = 1'b0;
    @(negedge clk);
    x_in_a = pack4(32768, 32768, 0, 0);
    in_valid_a = 1'b1;
    @(posedge clk);
    #1;
    in_valid_a = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    checkOutput("pre_rst_busy", in_ready_a, 0);
    rst = 1'b0;
    #1;
    checkOutput("async_rst_ov", out_valid_a, 0);
    checkOutput("async_rst_ready", in_ready_a, 1);
    @(negedge clk);
    rst = 1'b1;

    applyStimulus(0, pack4(0, 0, -100, 70000), lat);
    expectRun("after_rst", lat, 1, 3, 70000, 0, 0, 0);
    finishRun("after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
